// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: byte/half/word requests in, word-addressed single-port memory cycles out.
// Latency (accept edge to rsp_valid): error 1, word store 2, load 3, sub-word store (read-modify-write) 4.
// Backpressure: one request in flight; req_ready only in IDLE; response held stable until rsp_ready.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_*                 request channel (valid/ready), byte address, size, sign mode, store data
//   rsp_*                 response channel (valid/ready), load data and error flag
//   mem_read_*            registered read strobe/word address; read data + read-valid one cycle later
//   mem_write_*           registered write strobe/word address/data
module lsu_mem_ctrl #(
   parameter int _D = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_read_en,
   output logic [31:0] mem_read_addr,
   input  logic [31:0] mem_read_dat,
   input  logic        mem_r_v,
   output logic        mem_write_en,
   output logic [31:0] mem_write_addr,
   output logic [31:0] mem_write_dat
);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ISSUE,
      S_RD_DATA,
      S_RMW_ISSUE,
      S_RMW_DATA,
      S_WR_ISSUE,
      S_RESP
   } state_t;

   // Fields kept for the lifetime of an access. Only the low half of the
   // store data is needed: word stores load mem_write_dat at acceptance.
   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  size;
      logic        unsgn;
      logic [15:0] wdata;
   } req_t;

   state_t state_q, state_d;
   req_t   req_q, req_d;

   logic        rsp_valid_d;
   logic [31:0] rsp_rdata_d;
   logic        rsp_err_d;
   logic        mem_read_en_d;
   logic [31:0] mem_read_addr_d;
   logic        mem_write_en_d;
   logic [31:0] mem_write_addr_d;
   logic [31:0] mem_write_dat_d;

   logic [31:0] in_word;
   logic        dec_err;
   logic [31:0] cur_word;
   logic [31:0] byte_shift;
   logic [31:0] half_shift;
   logic [31:0] ld_val;
   logic [31:0] lane_mask;
   logic [31:0] lane_data;
   logic [31:0] merged;

   assign req_ready = (state_q == S_IDLE);

   // Decode of the incoming request; only meaningful in IDLE.
   assign in_word = {2'b00, req_addr[31:2]};
   assign dec_err = (req_size == 2'b11)
                 || ((req_size == SZ_HALF) && req_addr[0])
                 || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                 || (in_word >= 32'(_D));

   assign cur_word = {2'b00, req_q.addr[31:2]};

   // Lane extraction for loads: shift the addressed lane down to bit 0.
   assign byte_shift = mem_read_dat >> {req_q.addr[1:0], 3'b000};
   assign half_shift = mem_read_dat >> {req_q.addr[1], 4'b0000};

   always_comb begin
      ld_val = 32'h0;
      case (req_q.size)
         SZ_BYTE: ld_val = req_q.unsgn ? {24'h0, byte_shift[7:0]}
                                       : {{24{byte_shift[7]}}, byte_shift[7:0]};
         SZ_HALF: ld_val = req_q.unsgn ? {16'h0, half_shift[15:0]}
                                       : {{16{half_shift[15]}}, half_shift[15:0]};
         SZ_WORD: ld_val = mem_read_dat;
         default: ld_val = 32'h0;
      endcase
   end

   // Sub-word merge: replicate the store data across all lanes and let the
   // mask pick the addressed lane; everything else comes from the read word.
   always_comb begin
      lane_mask = 32'h0;
      lane_data = 32'h0;
      if (req_q.size == SZ_HALF) begin
         lane_mask = 32'h0000_FFFF << {req_q.addr[1], 4'b0000};
         lane_data = {2{req_q.wdata[15:0]}};
      end else begin
         lane_mask = 32'h0000_00FF << {req_q.addr[1:0], 3'b000};
         lane_data = {4{req_q.wdata[7:0]}};
      end
   end

   assign merged = (mem_read_dat & ~lane_mask) | (lane_data & lane_mask);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state plus next value of every registered output. Strobes default
   // low so each is high for exactly the one cycle of its issue state.
   always_comb begin
      state_d          = state_q;
      req_d            = req_q;
      rsp_valid_d      = rsp_valid;
      rsp_rdata_d      = rsp_rdata;
      rsp_err_d        = rsp_err;
      mem_read_en_d    = 1'b0;
      mem_read_addr_d  = mem_read_addr;
      mem_write_en_d   = 1'b0;
      mem_write_addr_d = mem_write_addr;
      mem_write_dat_d  = mem_write_dat;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               req_d.addr  = req_addr;
               req_d.size  = req_size;
               req_d.unsgn = req_unsigned;
               req_d.wdata = req_wdata[15:0];
               if (dec_err) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = 32'h0;
                  state_d     = S_RESP;
               end else if (!req_we) begin
                  mem_read_en_d   = 1'b1;
                  mem_read_addr_d = in_word;
                  state_d         = S_RD_ISSUE;
               end else if (req_size == SZ_WORD) begin
                  mem_write_en_d   = 1'b1;
                  mem_write_addr_d = in_word;
                  mem_write_dat_d  = req_wdata;
                  state_d          = S_WR_ISSUE;
               end else begin
                  mem_read_en_d   = 1'b1;
                  mem_read_addr_d = in_word;
                  state_d         = S_RMW_ISSUE;
               end
            end
         end
         S_RD_ISSUE: state_d = S_RD_DATA;
         S_RD_DATA: begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = !mem_r_v;
            rsp_rdata_d = mem_r_v ? ld_val : 32'h0;
            state_d     = S_RESP;
         end
         S_RMW_ISSUE: state_d = S_RMW_DATA;
         S_RMW_DATA: begin
            if (!mem_r_v) begin
               // Read failed: abandon the store rather than write a guessed word.
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = 32'h0;
               state_d     = S_RESP;
            end else begin
               mem_write_en_d   = 1'b1;
               mem_write_addr_d = cur_word;
               mem_write_dat_d  = merged;
               state_d          = S_WR_ISSUE;
            end
         end
         S_WR_ISSUE: begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = 32'h0;
            state_d     = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         req_q          <= '0;
         rsp_valid      <= 1'b0;
         rsp_rdata      <= 32'h0;
         rsp_err        <= 1'b0;
         mem_read_en    <= 1'b0;
         mem_read_addr  <= 32'h0;
         mem_write_en   <= 1'b0;
         mem_write_addr <= 32'h0;
         mem_write_dat  <= 32'h0;
      end else begin
         req_q          <= req_d;
         rsp_valid      <= rsp_valid_d;
         rsp_rdata      <= rsp_rdata_d;
         rsp_err        <= rsp_err_d;
         mem_read_en    <= mem_read_en_d;
         mem_read_addr  <= mem_read_addr_d;
         mem_write_en   <= mem_write_en_d;
         mem_write_addr <= mem_write_addr_d;
         mem_write_dat  <= mem_write_dat_d;
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl: directed vector table, reset-abort sequence, random traffic vs. reference model.
// Latency: checked per transaction against expected edge counts.
// Backpressure: responses are held off for a few cycles with junk requests presented meanwhile.
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_read_en;
   logic [31:0] mem_read_addr;
   logic [31:0] mem_read_dat;
   logic        mem_r_v;
   logic        mem_write_en;
   logic [31:0] mem_write_addr;
   logic [31:0] mem_write_dat;

   always #5 clk = ~clk;

   lsu_mem_ctrl #(._D(1024)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err),
      .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr),
      .mem_read_dat(mem_read_dat), .mem_r_v(mem_r_v),
      .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr),
      .mem_write_dat(mem_write_dat)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input int i);
      return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   // Memory behaviour: read data and read-valid one cycle after the strobe.
   logic [31:0] mem [0:1023];
   logic [31:0] ref_mem [0:1023];
   bit          mem_init_done = 1'b0;
   logic        rv_ok = 1'b1;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   int          both_cnt = 0;

   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
         mem_init_done <= 1'b1;
      end else if (mem_write_en && (mem_write_addr < 32'd1024)) begin
         mem[mem_write_addr[9:0]] <= mem_write_dat;
      end
      if (mem_read_en) begin
         mem_read_dat <= (mem_read_addr < 32'd1024) ? mem[mem_read_addr[9:0]] : 32'h0;
         mem_r_v      <= rv_ok;
      end else begin
         mem_read_dat <= $urandom;
         mem_r_v      <= 1'($urandom_range(0, 1));
      end
      rd_cnt   <= rd_cnt + int'(mem_read_en);
      wr_cnt   <= wr_cnt + int'(mem_write_en);
      both_cnt <= both_cnt + int'(mem_read_en && mem_write_en);
   end

   // Reference model: alignment/range rules, lane arithmetic and latencies.
   task automatic model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata, input logic rv,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int nrd, output int nwr);
      int word, off, nb;
      logic [31:0] mask, w, v;
      word = int'(addr >> 2);
      off  = int'(addr[1:0]);
      nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      rdata = 32'h0; err = 1'b0; lat = 0; nrd = 0; nwr = 0;
      if (size == 2'd3 || (off % nb) != 0 || word >= 1024) begin
         err = 1'b1; lat = 1;
         return;
      end
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      w = ref_mem[word];
      if (!we) begin
         nrd = 1; lat = 3;
         if (!rv) begin err = 1'b1; return; end
         v = (w >> (8 * off)) & mask;
         if (!uns && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
         rdata = v;
      end else if (nb == 4) begin
         nwr = 1; lat = 2;
         ref_mem[word] = wdata;
      end else begin
         nrd = 1;
         if (!rv) begin err = 1'b1; lat = 3; return; end
         nwr = 1; lat = 4;
         ref_mem[word] = (w & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
      end
   endtask

   // One complete transaction with all checks against the supplied expectations.
   task automatic apply(input string tag, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic rv, input int hold, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat, input int exp_rd, input int exp_wr);
      int rd0, wr0, n, lat;
      @(negedge clk);
      rv_ok = rv; req_we = we; req_addr = addr; req_size = size;
      req_unsigned = uns; req_wdata = wdata; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
      rd0 = rd_cnt; wr0 = wr_cnt;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
      chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, ".rdata"}, rsp_rdata, exp_rdata);
      chk({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1; req_we = 1'($urandom_range(0, 1)); req_addr = $urandom_range(0, 63);
         req_size = 2'($urandom_range(0, 2)); req_wdata = $urandom;
         @(negedge clk);
         chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
         chk({tag, ".hold_rdata"}, rsp_rdata, exp_rdata);
         chk({tag, ".hold_err"}, 32'(rsp_err), 32'(exp_err));
         chk({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      chk({tag, ".rsp_drop"}, 32'(rsp_valid), 32'd0);
      chk({tag, ".rd_strobes"}, 32'(rd_cnt - rd0), 32'(exp_rd));
      chk({tag, ".wr_strobes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] wdata;
      logic        rv;
      int          hold;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_rd;
      int          exp_wr;
      logic        mchk;
      logic [31:0] exp_mem;
   } vec_t;

   function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [1:0] size,
                               input logic uns, input logic [31:0] wdata, input logic rv,
                               input int hold, input logic [31:0] er, input logic ee,
                               input int el, input int erd, input int ewr,
                               input logic mchk, input logic [31:0] em);
      vec_t v;
      v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata; v.rv = rv;
      v.hold = hold; v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el;
      v.exp_rd = erd; v.exp_wr = ewr; v.mchk = mchk; v.exp_mem = em;
      return v;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares", n_vec, n_bad);
      $fatal(1);
   end

   initial begin
      vec_t tbl[$];
      logic [31:0] m_rdata;
      logic        m_err;
      int          m_lat, m_rd, m_wr, wr0, word;
      logic        we, uns, rv;
      logic [31:0] addr, wdata;
      logic [1:0]  size;

      for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);

      //            we  addr        sz uns wdata          rv hold rdata         err lat rd wr mchk mem
      tbl.push_back(mk(1, 32'h10,   2, 0, 32'h1122_3344, 1, 0, 32'h0,         0, 2, 0, 1, 1, 32'h1122_3344));
      tbl.push_back(mk(0, 32'h10,   2, 0, 32'h0,         1, 5, 32'h1122_3344, 0, 3, 1, 0, 0, 32'h0));
      tbl.push_back(mk(1, 32'h11,   0, 0, 32'h1234_56AB, 1, 0, 32'h0,         0, 4, 1, 1, 1, 32'h1122_AB44));
      tbl.push_back(mk(0, 32'h11,   0, 0, 32'h0,         1, 1, 32'hFFFF_FFAB, 0, 3, 1, 0, 0, 32'h0));
      tbl.push_back(mk(0, 32'h11,   0, 1, 32'h0,         1, 0, 32'h0000_00AB, 0, 3, 1, 0, 0, 32'h0));
      tbl.push_back(mk(1, 32'h12,   1, 0, 32'hDEAD_8001, 1, 0, 32'h0,         0, 4, 1, 1, 1, 32'h8001_AB44));
      tbl.push_back(mk(0, 32'h12,   1, 0, 32'h0,         1, 0, 32'hFFFF_8001, 0, 3, 1, 0, 0, 32'h0));
      tbl.push_back(mk(0, 32'h12,   1, 1, 32'h0,         1, 0, 32'h0000_8001, 0, 3, 1, 0, 0, 32'h0));
      tbl.push_back(mk(0, 32'h13,   1, 0, 32'h0,         1, 2, 32'h0,         1, 1, 0, 0, 0, 32'h0));
      tbl.push_back(mk(0, 32'h1000, 2, 0, 32'h0,         1, 0, 32'h0,         1, 1, 0, 0, 0, 32'h0));
      tbl.push_back(mk(0, 32'h10,   3, 0, 32'h0,         1, 0, 32'h0,         1, 1, 0, 0, 0, 32'h0));
      tbl.push_back(mk(1, 32'h12,   2, 0, 32'hFFFF_FFFF, 1, 0, 32'h0,         1, 1, 0, 0, 1, 32'h8001_AB44));
      tbl.push_back(mk(0, 32'h10,   0, 0, 32'h0,         1, 0, 32'h0000_0044, 0, 3, 1, 0, 0, 32'h0));
      tbl.push_back(mk(0, 32'h13,   0, 0, 32'h0,         1, 0, 32'hFFFF_FF80, 0, 3, 1, 0, 0, 32'h0));
      tbl.push_back(mk(1, 32'hFFC,  2, 0, 32'hCAFE_F00D, 1, 0, 32'h0,         0, 2, 0, 1, 1, 32'hCAFE_F00D));
      tbl.push_back(mk(0, 32'hFFE,  1, 1, 32'h0,         1, 0, 32'h0000_CAFE, 0, 3, 1, 0, 0, 32'h0));
      tbl.push_back(mk(0, 32'h10,   2, 0, 32'h0,         0, 0, 32'h0,         1, 3, 1, 0, 0, 32'h0));
      tbl.push_back(mk(1, 32'h10,   0, 0, 32'h0000_0055, 0, 1, 32'h0,         1, 3, 1, 0, 1, 32'h8001_AB44));
      tbl.push_back(mk(1, 32'h1003, 0, 0, 32'h0000_0077, 1, 0, 32'h0,         1, 1, 0, 0, 0, 32'h0));

      req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_size = 2'b00;
      req_unsigned = 1'b0; req_wdata = 32'h0; rsp_ready = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset.rsp_rdata", rsp_rdata, 32'h0);
      chk("reset.rsp_err", 32'(rsp_err), 32'd0);
      chk("reset.mem_read_en", 32'(mem_read_en), 32'd0);
      chk("reset.mem_write_en", 32'(mem_write_en), 32'd0);
      chk("reset.mem_read_addr", mem_read_addr, 32'h0);
      chk("reset.mem_write_addr", mem_write_addr, 32'h0);
      chk("reset.mem_write_dat", mem_write_dat, 32'h0);
      chk("reset.req_ready", 32'(req_ready), 32'd1);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         apply($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns,
               tbl[i].wdata, tbl[i].rv, tbl[i].hold, tbl[i].exp_rdata, tbl[i].exp_err,
               tbl[i].exp_lat, tbl[i].exp_rd, tbl[i].exp_wr);
         // Keep the model's memory image in step with the directed stores.
         model(tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wdata, tbl[i].rv,
               m_rdata, m_err, m_lat, m_rd, m_wr);
         if (tbl[i].mchk) chk($sformatf("vec%0d.mem", i), mem[tbl[i].addr[11:2]], tbl[i].exp_mem);
      end

      // Reset while the read-modify-write is waiting on its read data.
      @(negedge clk);
      rv_ok = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_size = 2'b00;
      req_wdata = 32'h0000_00EE; req_valid = 1'b1;
      chk("rst_rmw.req_ready", 32'(req_ready), 32'd1);
      wr0 = wr_cnt;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("rst_rmw.read_strobe", 32'(mem_read_en), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_rmw.rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rmw.rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rmw.rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_rmw.mem_read_en", 32'(mem_read_en), 32'd0);
      chk("rst_rmw.mem_write_en", 32'(mem_write_en), 32'd0);
      chk("rst_rmw.mem_read_addr", mem_read_addr, 32'h0);
      chk("rst_rmw.mem_write_addr", mem_write_addr, 32'h0);
      chk("rst_rmw.mem_write_dat", mem_write_dat, 32'h0);
      chk("rst_rmw.req_ready", 32'(req_ready), 32'd1);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_rmw.no_write", 32'(wr_cnt - wr0), 32'd0);
      chk("rst_rmw.no_rsp", 32'(rsp_valid), 32'd0);
      chk("rst_rmw.mem_word", mem[8], ref_mem[8]);

      // Random traffic against the reference model.
      for (int t = 0; t < 200; t++) begin
         we    = 1'($urandom_range(0, 1));
         size  = 2'($urandom_range(0, 3));
         uns   = 1'($urandom_range(0, 1));
         wdata = $urandom;
         rv    = ($urandom_range(0, 9) != 0);
         case ($urandom_range(0, 19))
            0:       addr = $urandom;
            1:       addr = 32'hFF8 + 32'($urandom_range(0, 15));
            default: addr = 32'($urandom_range(0, 31));
         endcase
         model(we, addr, size, uns, wdata, rv, m_rdata, m_err, m_lat, m_rd, m_wr);
         apply($sformatf("rnd%0d", t), we, addr, size, uns, wdata, rv,
               int'($urandom_range(0, 2)), m_rdata, m_err, m_lat, m_rd, m_wr);
         word = int'(addr >> 2);
         if (word < 1024) chk($sformatf("rnd%0d.mem", t), mem[word[9:0]], ref_mem[word]);
      end

      chk("strobe_overlap", 32'(both_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
